// File: rtl/ble_telemetry_tx.sv
// ble_telemetry_tx
// UART transmitter returning MPU attitude telemetry to the BLE module.
// Each accepted request sends one fixed 8-byte 8N1 frame:
//   SYNC, roll_hi, roll_lo, pitch_hi, pitch_lo, yaw_hi, yaw_lo, CHK
// Every angle is sign-extended to 16 bits and sent big-endian.
// CHK is the XOR of the six angle bytes. SYNC is not included.
//
// Ports:
//   clock    system clock
//   reset_n  asynchronous active-low reset (tx is forced idle-high)
//   send     frame request, sampled every cycle
//   roll     signed 10-bit MPU angle
//   pitch    signed 10-bit MPU angle
//   yaw      signed 10-bit MPU angle
//   tx       UART serial out, idle high
//   busy     high while the frame bits are on the line
//   done     one-cycle pulse after the final stop bit
//   dropped  saturating count of requests that arrived while not idle
module ble_telemetry_tx #(
  parameter int unsigned CLK_HZ       = 32'd100_000_000,
  parameter int unsigned BAUD         = 32'd115_200,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [9:0] roll,
  input  logic [9:0] pitch,
  input  logic [9:0] yaw,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [7:0] dropped
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 32'd1);
  localparam logic [2:0]  IDX_LAST = 3'd7;
  localparam int unsigned EXT_W    = 32'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Sign-extend a 10-bit angle to the 16-bit wire format.
  function automatic logic [15:0] sign_ext(input logic [9:0] v);
    sign_ext = {{EXT_W{v[9]}}, v};
  endfunction

  // XOR of the six angle bytes.
  function automatic logic [7:0] xor_chk(input logic [9:0] r,
                                         input logic [9:0] p,
                                         input logic [9:0] y);
    logic [15:0] rs;
    logic [15:0] ps;
    logic [15:0] ys;
    rs = sign_ext(r);
    ps = sign_ext(p);
    ys = sign_ext(y);
    xor_chk = rs[15:8] ^ rs[7:0] ^ ps[15:8] ^ ps[7:0] ^ ys[15:8] ^ ys[7:0];
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [15:0] timer_r;
  logic [15:0] timer_s;
  logic [2:0]  bit_idx_r;
  logic [2:0]  bit_idx_s;
  logic [2:0]  byte_idx_r;
  logic [2:0]  byte_idx_s;
  logic        load_s;
  logic        bit_end_s;
  logic        drop_s;

  logic [15:0] roll_r;
  logic [15:0] pitch_r;
  logic [15:0] yaw_r;
  logic [7:0]  chk_r;
  logic [7:0]  byte_s;

  logic        tx_r;
  logic        busy_r;
  logic        done_r;
  logic [7:0]  dropped_r;
  logic        tx_s;
  logic        busy_s;
  logic        done_s;

  // Next-state logic: bit timer, bit/byte sequencing and frame accept.
  always_comb begin
    state_s    = state_r;
    timer_s    = timer_r;
    bit_idx_s  = bit_idx_r;
    byte_idx_s = byte_idx_r;
    load_s     = 1'b0;
    bit_end_s  = (timer_r == BIT_LAST);
    case (state_r)
      ST_IDLE: begin
        if (send) begin
          state_s    = ST_START;
          timer_s    = 16'd0;
          bit_idx_s  = 3'd0;
          byte_idx_s = 3'd0;
          load_s     = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_s   = ST_DATA;
          timer_s   = 16'd0;
          bit_idx_s = 3'd0;
        end else begin
          timer_s = timer_r + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          timer_s = 16'd0;
          if (bit_idx_r == IDX_LAST) begin
            state_s = ST_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          timer_s = timer_r + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          timer_s = 16'd0;
          if (byte_idx_r == IDX_LAST) begin
            state_s = ST_DONE;
          end else begin
            state_s    = ST_START;
            byte_idx_s = byte_idx_r + 3'd1;
          end
        end else begin
          timer_s = timer_r + 16'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Requests are refused in every non-idle state, DONE included.
    drop_s = send && (state_r != ST_IDLE) && (dropped_r != 8'hFF);
  end

  // Byte currently on the wire, chosen from the latched frame contents.
  always_comb begin
    byte_s = 8'hFF;
    case (byte_idx_s)
      3'd0:    byte_s = SYNC_BYTE;
      3'd1:    byte_s = roll_r[15:8];
      3'd2:    byte_s = roll_r[7:0];
      3'd3:    byte_s = pitch_r[15:8];
      3'd4:    byte_s = pitch_r[7:0];
      3'd5:    byte_s = yaw_r[15:8];
      3'd6:    byte_s = yaw_r[7:0];
      3'd7:    byte_s = chk_r;
      default: byte_s = 8'hFF;
    endcase
  end

  // Output values for the upcoming state, so the output flops track the FSM exactly.
  always_comb begin
    tx_s   = 1'b1;
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      ST_START: begin
        tx_s   = 1'b0;
        busy_s = 1'b1;
      end
      ST_DATA: begin
        tx_s   = byte_s[bit_idx_s];
        busy_s = 1'b1;
      end
      ST_STOP: begin
        tx_s   = 1'b1;
        busy_s = 1'b1;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        tx_s = 1'b1;
      end
    endcase
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      timer_r    <= 16'd0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 3'd0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      dropped_r  <= 8'd0;
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      bit_idx_r  <= bit_idx_s;
      byte_idx_r <= byte_idx_s;
      tx_r       <= tx_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      if (drop_s) begin
        dropped_r <= dropped_r + 8'd1;
      end
    end
  end

  // Shadow copy of the angles and checksum, captured only on accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      roll_r  <= 16'd0;
      pitch_r <= 16'd0;
      yaw_r   <= 16'd0;
      chk_r   <= 8'd0;
    end else if (load_s) begin
      roll_r  <= sign_ext(roll);
      pitch_r <= sign_ext(pitch);
      yaw_r   <= sign_ext(yaw);
      chk_r   <= xor_chk(roll, pitch, yaw);
    end
  end

  assign tx      = tx_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign dropped = dropped_r;

endmodule
